l1_cache_control: RTL and testbench
===================================

// Module: l1_cache_control
// PURPOSE
//  Sequencing FSM for the 2-way L1 cache datapath: hit/miss resolution, dirty-victim
//  writeback to L2, line allocate from L2. Drives the L1 write-logic mux selects
//  (fill vs CPU merge), array load enables and the L2 handshake. Holds per-set LRU
//  bits and saturating hit/miss counters. Sits between the CPU mem port and L2.
// PARAMETERS
//  SET_BITS  3   index width; the LRU array holds 2**SET_BITS bits
//  CNT_W     16  width of the hit/miss performance counters
// PORTS
//  clk            in   1         rising-edge clock
//  rst_n          in   1         asynchronous, active-low reset
//  mem_read       in   1         CPU read request, held until mem_resp
//  mem_write      in   1         CPU write request, held until mem_resp
//  index          in   SET_BITS  set index of the current request
//  hit            in   2         per-way tag match AND valid, from datapath
//  dirty          in   2         per-way dirty bits of the indexed set
//  valid          in   2         per-way valid bits of the indexed set
//  l2_resp        in   1         L2 transaction complete, 1-cycle pulse
//  mem_resp       out  1         CPU request done, 1-cycle pulse
//  l2_read        out  1         L2 fill request; also the write-logic fill select
//  l2_write       out  1         L2 writeback request
//  wb_addr_sel    out  1         1 = L2 address uses the victim tag (writeback)
//  load_data      out  2         per-way data array write enable
//  load_tag       out  2         per-way tag+valid write enable (valid<=1)
//  set_dirty      out  2         per-way dirty<=1
//  clr_dirty      out  2         per-way dirty<=0
//  way_sel        out  1         way routed to the CPU read mux / write logic
//  hit_count      out  CNT_W     requests resolved on first lookup, saturating
//  miss_count     out  CNT_W     requests needing allocate, saturating
// BEHAVIOUR
//  Reset (async, any state): state=CHECK, LRU array all 0, counters 0; all
//   outputs 0 in the same cycle; an in-flight L2 transaction is abandoned.
//  Request: req = mem_read|mem_write. Both high at once is treated as a write.
//  States: CHECK, WRITEBACK, ALLOCATE. Outputs combinational from state and inputs.
//  CHECK, no req: all outputs 0, stay.
//  CHECK, req & |hit: way h = hit[1]. mem_resp=1, way_sel=h; on a write also
//   load_data[h]=1, set_dirty[h]=1 (l2_read=0, so write logic merges CPU bytes).
//   LRU[index] <= ~h. hit_count++ unless the request is a replay. Stay in CHECK.
//  CHECK, req & no hit: victim v = LRU[index]. valid[v]&dirty[v] -> WRITEBACK,
//   else -> ALLOCATE. mem_resp=0. miss_count++ (once per request).
//  WRITEBACK: l2_write=1, wb_addr_sel=1, way_sel=v; hold until l2_resp, then -> ALLOCATE.
//  ALLOCATE: l2_read=1, way_sel=v; on l2_resp: load_data[v]=1, load_tag[v]=1,
//   clr_dirty[v]=1, -> CHECK. The request replays in CHECK and hits 1 cycle later.
//  Latency: hit = 0 wait cycles (mem_resp in the request cycle). Clean miss = L2
//   latency + 1. Dirty miss = 2x L2 latency + 1.
//  Victim v is latched on leaving CHECK and stays stable through WB/ALLOCATE.
//  Replay flag is set on the ALLOCATE->CHECK transition and cleared on mem_resp,
//   so the replayed hit does not bump hit_count.
//  A request dropped mid-miss still finishes its fill; no mem_resp is issued after
//   it drops.
//  l2_resp seen in CHECK is ignored. l2_read and l2_write are never high together.
//  Counters saturate at all-ones and do not wrap.
// TESTING
//  1 Read, hit=2'b01 -> mem_resp same cycle, way_sel=0, LRU[index]=1, hit_count=1.
//  2 Write, hit=2'b10 -> load_data=2'b10, set_dirty=2'b10, mem_resp=1, l2_read=0.
//  3 Read miss, LRU=0, valid=2'b01, dirty=2'b01 -> l2_write until l2_resp (wb_addr_sel=1),
//    then l2_read; on l2_resp load_tag=2'b01, clr_dirty=2'b01; hit next cycle;
//    miss_count=1, hit_count=0.
//  4 Clean miss, valid=0 -> straight to ALLOCATE; no l2_write ever asserted.
//  5 rst_n low during WRITEBACK -> l2_write drops asynchronously; state=CHECK; counters 0.
//  6 Force hit_count to all-ones, then one more hit -> value holds at all-ones.

Source files
------------

// File: rtl/l1_cache_control.sv
// Sequencing FSM for a 2-way L1 cache: hit/miss resolution, dirty-victim writeback, allocate from L2.
// Latency: hit answers in the request cycle; clean miss = L2 latency + 1; dirty miss = 2x L2 latency + 1.
// Backpressure: the CPU holds mem_read/mem_write until mem_resp; L2 phases hold until the l2_resp pulse.
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   mem_read, mem_write, index         CPU request (a write wins if both are high)
//   hit, dirty, valid                  per-way status of the indexed set, from the datapath
//   l2_resp                            L2 transaction complete (1-cycle pulse)
//   mem_resp                           CPU request done (1-cycle pulse)
//   l2_read, l2_write, wb_addr_sel     L2 handshake; l2_read doubles as the write-logic fill select
//   load_data, load_tag                per-way array write enables
//   set_dirty, clr_dirty               per-way dirty bit control
//   way_sel                            way routed to the read mux / write logic
//   hit_count, miss_count              saturating performance counters
module l1_cache_control #(
    parameter int SET_BITS = 3,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [SET_BITS-1:0] index,
    input  logic [1:0]          hit,
    input  logic [1:0]          dirty,
    input  logic [1:0]          valid,
    input  logic                l2_resp,
    output logic                mem_resp,
    output logic                l2_read,
    output logic                l2_write,
    output logic                wb_addr_sel,
    output logic [1:0]          load_data,
    output logic [1:0]          load_tag,
    output logic [1:0]          set_dirty,
    output logic [1:0]          clr_dirty,
    output logic                way_sel,
    output logic [CNT_W-1:0]    hit_count,
    output logic [CNT_W-1:0]    miss_count
);

    localparam int NSETS = 1 << SET_BITS;

    typedef enum logic [1:0] {
        CHECK     = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NSETS-1:0]   lru_q, lru_d;
    logic               victim_q, victim_d;
    logic               replay_q, replay_d;
    logic [CNT_W-1:0]   hit_count_q, hit_count_d;
    logic [CNT_W-1:0]   miss_count_q, miss_count_d;

    logic               req;
    logic               hit_way;
    logic               lru_way;
    logic               mem_resp_c, l2_read_c, l2_write_c, wb_addr_sel_c, way_sel_c;
    logic [1:0]         load_data_c, load_tag_c, set_dirty_c, clr_dirty_c;

    always_comb begin
        req           = mem_read | mem_write;
        hit_way       = hit[1];
        lru_way       = lru_q[index];
        state_d       = state_q;
        lru_d         = lru_q;
        victim_d      = victim_q;
        replay_d      = replay_q;
        hit_count_d   = hit_count_q;
        miss_count_d  = miss_count_q;
        mem_resp_c    = 1'b0;
        l2_read_c     = 1'b0;
        l2_write_c    = 1'b0;
        wb_addr_sel_c = 1'b0;
        way_sel_c     = 1'b0;
        load_data_c   = 2'b00;
        load_tag_c    = 2'b00;
        set_dirty_c   = 2'b00;
        clr_dirty_c   = 2'b00;

        case (state_q)
            CHECK: begin
                if (!req) begin
                    // A request dropped mid-miss never replays; forget the flag.
                    replay_d = 1'b0;
                end else if (|hit) begin
                    mem_resp_c = 1'b1;
                    way_sel_c  = hit_way;
                    if (mem_write) begin
                        // l2_read stays low, so the write logic merges CPU bytes.
                        load_data_c[hit_way] = 1'b1;
                        set_dirty_c[hit_way] = 1'b1;
                    end
                    lru_d[index] = ~hit_way;
                    replay_d     = 1'b0;
                    if (!replay_q && hit_count_q != {CNT_W{1'b1}})
                        hit_count_d = hit_count_q + 1'b1;
                end else begin
                    // Victim is frozen here so WB/ALLOCATE see a stable way.
                    victim_d = lru_way;
                    state_d  = (valid[lru_way] && dirty[lru_way]) ? WRITEBACK : ALLOCATE;
                    if (!replay_q && miss_count_q != {CNT_W{1'b1}})
                        miss_count_d = miss_count_q + 1'b1;
                end
            end
            WRITEBACK: begin
                l2_write_c    = 1'b1;
                wb_addr_sel_c = 1'b1;
                way_sel_c     = victim_q;
                if (l2_resp)
                    state_d = ALLOCATE;
            end
            ALLOCATE: begin
                l2_read_c = 1'b1;
                way_sel_c = victim_q;
                if (l2_resp) begin
                    load_data_c[victim_q] = 1'b1;
                    load_tag_c[victim_q]  = 1'b1;
                    clr_dirty_c[victim_q] = 1'b1;
                    replay_d              = 1'b1;
                    state_d               = CHECK;
                end
            end
            default: state_d = CHECK;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= CHECK;
            lru_q        <= '0;
            victim_q     <= 1'b0;
            replay_q     <= 1'b0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            lru_q        <= lru_d;
            victim_q     <= victim_d;
            replay_q     <= replay_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    // Outputs are forced low while reset is asserted, even with a request held.
    assign mem_resp    = rst_n & mem_resp_c;
    assign l2_read     = rst_n & l2_read_c;
    assign l2_write    = rst_n & l2_write_c;
    assign wb_addr_sel = rst_n & wb_addr_sel_c;
    assign way_sel     = rst_n & way_sel_c;
    assign load_data   = {2{rst_n}} & load_data_c;
    assign load_tag    = {2{rst_n}} & load_tag_c;
    assign set_dirty   = {2{rst_n}} & set_dirty_c;
    assign clr_dirty   = {2{rst_n}} & clr_dirty_c;
    assign hit_count   = hit_count_q;
    assign miss_count  = miss_count_q;

endmodule

// File: tb/tb_l1_cache_control.sv
module tb_l1_cache_control;

    localparam int SB   = 3;
    localparam int CW   = 6;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mem_read, mem_write;
    logic [SB-1:0] index;
    logic [1:0]    hit, dirty, valid;
    logic          l2_resp;
    logic          mem_resp, l2_read, l2_write, wb_addr_sel, way_sel;
    logic [1:0]    load_data, load_tag, set_dirty, clr_dirty;
    logic [CW-1:0] hit_count, miss_count;

    l1_cache_control #(.SET_BITS(SB), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .index(index), .hit(hit), .dirty(dirty), .valid(valid), .l2_resp(l2_resp),
        .mem_resp(mem_resp), .l2_read(l2_read), .l2_write(l2_write),
        .wb_addr_sel(wb_addr_sel), .load_data(load_data), .load_tag(load_tag),
        .set_dirty(set_dirty), .clr_dirty(clr_dirty), .way_sel(way_sel),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // Observed output bundle: {mem_resp,l2_read,l2_write,wb_addr_sel,load_data,load_tag,set_dirty,clr_dirty,way_sel}
    wire [12:0] obs = {mem_resp, l2_read, l2_write, wb_addr_sel,
                       load_data, load_tag, set_dirty, clr_dirty, way_sel};

    int n_pass = 0;
    int n_total = 0;

    // Behavioural model: the cache contents the datapath would report, plus LRU and counters.
    int         m_tag [8][2];
    logic [1:0] m_val [8];
    logic [1:0] m_dirty [8];
    bit         m_lru [8];
    int         exp_hit, exp_miss;

    function automatic logic [12:0] ev(bit resp, bit rd, bit wr, bit wb,
                                       logic [1:0] ld, logic [1:0] lt,
                                       logic [1:0] sd, logic [1:0] cd, bit ws);
        return {resp, rd, wr, wb, ld, lt, sd, cd, ws};
    endfunction

    function automatic logic [1:0] lookup(input int idx, input int tag);
        logic [1:0] r;
        r = 2'b00;
        for (int w = 0; w < 2; w++)
            if (m_val[idx][w] && m_tag[idx][w] == tag) r[w] = 1'b1;
        return r;
    endfunction

    function automatic logic [1:0] onehot(input bit w);
        return w ? 2'b10 : 2'b01;
    endfunction

    function automatic int sat_inc(input int v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    task automatic model_clear;
        for (int s = 0; s < 8; s++) begin
            m_val[s] = 2'b00; m_dirty[s] = 2'b00; m_lru[s] = 1'b0;
            m_tag[s][0] = -1; m_tag[s][1] = -1;
        end
        exp_hit = 0; exp_miss = 0;
    endtask

    task automatic apply_reset;
        rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; index = '0;
        hit = 2'b00; dirty = 2'b00; valid = 2'b00; l2_resp = 1'b0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One CPU request from the CHECK state to its mem_resp. Starts and ends on a negedge.
    task automatic do_request(input bit wr, input int idx, input int tag,
                              input int lat_wb, input int lat_al);
        logic [1:0] h, ld;
        bit         v, dmiss, hw;
        string      tn;
        h = lookup(idx, tag);
        mem_write = wr; mem_read = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        index = SB'(idx); hit = h; valid = m_val[idx]; dirty = m_dirty[idx];
        l2_resp = 1'b0;
        #2;
        if (h != 2'b00) begin
            hw = h[1];
            ld = wr ? onehot(hw) : 2'b00;
            n_total++;
            if (obs !== ev(1, 0, 0, 0, ld, 2'b00, ld, 2'b00, hw))
                $display("FAIL hit_outputs set=%0d got=%b exp=%b", idx, obs, ev(1, 0, 0, 0, ld, 2'b00, ld, 2'b00, hw));
            else n_pass++;
            m_lru[idx] = ~hw;
            if (wr) m_dirty[idx][hw] = 1'b1;
            exp_hit = sat_inc(exp_hit);
            @(negedge clk);
        end else begin
            v = m_lru[idx];
            dmiss = m_val[idx][v] && m_dirty[idx][v];
            n_total++;
            if (obs !== 13'd0)
                $display("FAIL miss_check_outputs set=%0d got=%b exp=%b", idx, obs, 13'd0);
            else n_pass++;
            exp_miss = sat_inc(exp_miss);
            @(negedge clk);
            if (dmiss) begin
                for (int c = 1; c <= lat_wb; c++) begin
                    l2_resp = (c == lat_wb);
                    #2;
                    n_total++;
                    if (obs !== ev(0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 2'b00, v))
                        $display("FAIL writeback_outputs set=%0d cyc=%0d got=%b exp=%b", idx, c, obs, ev(0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 2'b00, v));
                    else n_pass++;
                    @(negedge clk);
                end
            end
            for (int c = 1; c <= lat_al; c++) begin
                l2_resp = (c == lat_al);
                ld = (c == lat_al) ? onehot(v) : 2'b00;
                #2;
                n_total++;
                if (obs !== ev(0, 1, 0, 0, ld, ld, 2'b00, ld, v))
                    $display("FAIL allocate_outputs set=%0d cyc=%0d got=%b exp=%b", idx, c, obs, ev(0, 1, 0, 0, ld, ld, 2'b00, ld, v));
                else n_pass++;
                @(negedge clk);
            end
            l2_resp = 1'b0;
            m_tag[idx][v] = tag; m_val[idx][v] = 1'b1; m_dirty[idx][v] = 1'b0;
            // Replay: the datapath now reports a hit in the filled way; not counted as a hit.
            hit = lookup(idx, tag); valid = m_val[idx]; dirty = m_dirty[idx];
            ld = wr ? onehot(v) : 2'b00;
            #2;
            n_total++;
            if (obs !== ev(1, 0, 0, 0, ld, 2'b00, ld, 2'b00, v))
                $display("FAIL replay_outputs set=%0d got=%b exp=%b", idx, obs, ev(1, 0, 0, 0, ld, 2'b00, ld, 2'b00, v));
            else n_pass++;
            m_lru[idx] = ~v;
            if (wr) m_dirty[idx][v] = 1'b1;
            @(negedge clk);
        end
        mem_read = 1'b0; mem_write = 1'b0; hit = 2'b00;
        tn = (h != 2'b00) ? "hit" : "miss";
        n_total++;
        if (hit_count !== CW'(exp_hit) || miss_count !== CW'(exp_miss))
            $display("FAIL counters_after_%s got=%0d/%0d exp=%0d/%0d", tn, hit_count, miss_count, exp_hit, exp_miss);
        else n_pass++;
    endtask

    // Idle cycle in CHECK; a stray l2_resp here must be ignored.
    task automatic idle_cycle(input bit stray_resp);
        mem_read = 1'b0; mem_write = 1'b0; hit = 2'b00; l2_resp = stray_resp;
        #2;
        n_total++;
        if (obs !== 13'd0) $display("FAIL idle_outputs got=%b exp=%b", obs, 13'd0);
        else n_pass++;
        @(negedge clk);
        l2_resp = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; model_clear();
        mem_read = 1'b1; mem_write = 1'b0; index = 3'd1; hit = 2'b01;
        valid = 2'b01; dirty = 2'b00; l2_resp = 1'b0;
        #3;
        n_total++;
        if (obs !== 13'd0) $display("FAIL reset_outputs got=%b exp=%b", obs, 13'd0);
        else n_pass++;
        n_total++;
        if (hit_count !== '0 || miss_count !== '0)
            $display("FAIL reset_counters got=%0d/%0d exp=0/0", hit_count, miss_count);
        else n_pass++;
        mem_read = 1'b0; hit = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycle(1'b0);
    endtask

    task automatic test_read_hit;
        apply_reset();
        m_val[3] = 2'b01; m_tag[3][0] = 7;
        do_request(1'b0, 3, 7, 1, 1);
        // LRU[3] is now 1: a miss on set 3 must pick way 1 as victim.
        do_request(1'b0, 3, 9, 1, 2);
    endtask

    task automatic test_write_hit;
        apply_reset();
        m_val[4] = 2'b10; m_tag[4][1] = 3;
        do_request(1'b1, 4, 3, 1, 1);
    endtask

    task automatic test_dirty_miss;
        apply_reset();
        m_val[5] = 2'b01; m_dirty[5] = 2'b01; m_tag[5][0] = 1;
        do_request(1'b0, 5, 2, 3, 2);
        n_total++;
        if (hit_count !== CW'(0) || miss_count !== CW'(1))
            $display("FAIL dirty_miss_counts got=%0d/%0d exp=0/1", hit_count, miss_count);
        else n_pass++;
    endtask

    task automatic test_clean_miss;
        apply_reset();
        do_request(1'b1, 6, 4, 1, 3);
        idle_cycle(1'b1);
        do_request(1'b0, 6, 4, 1, 1);
    endtask

    task automatic test_reset_in_writeback;
        apply_reset();
        m_val[2] = 2'b01; m_dirty[2] = 2'b01; m_tag[2][0] = 5;
        mem_read = 1'b1; mem_write = 1'b0; index = 3'd2; hit = 2'b00;
        valid = m_val[2]; dirty = m_dirty[2]; l2_resp = 1'b0;
        @(negedge clk);
        #2;
        n_total++;
        if (obs !== ev(0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0))
            $display("FAIL wb_entered got=%b exp=%b", obs, ev(0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0));
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (obs !== 13'd0) $display("FAIL wb_async_reset got=%b exp=%b", obs, 13'd0);
        else n_pass++;
        n_total++;
        if (hit_count !== '0 || miss_count !== '0)
            $display("FAIL wb_reset_counters got=%0d/%0d exp=0/0", hit_count, miss_count);
        else n_pass++;
        mem_read = 1'b0;
        for (int s = 0; s < 8; s++) m_lru[s] = 1'b0;
        exp_hit = 0; exp_miss = 0;
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycle(1'b0);
        do_request(1'b0, 2, 5, 1, 1);
    endtask

    task automatic test_saturation;
        apply_reset();
        m_val[0] = 2'b01; m_tag[0][0] = 0;
        for (int i = 0; i < CMAX + 3; i++) do_request(1'b0, 0, 0, 1, 1);
        n_total++;
        if (hit_count !== {CW{1'b1}})
            $display("FAIL hit_saturation got=%0d exp=%0d", hit_count, CMAX);
        else n_pass++;
    endtask

    task automatic test_random;
        apply_reset();
        for (int i = 0; i < 200; i++) begin
            do_request(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                       int'($urandom_range(0, 3)), int'($urandom_range(1, 4)),
                       int'($urandom_range(1, 4)));
            if ($urandom_range(0, 2) == 0) idle_cycle(1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_read_hit();
        test_write_hit();
        test_dirty_miss();
        test_clean_miss();
        test_reset_in_writeback();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
